// File: rtl/camera_controller_if.sv
// Camera controller frame-update bus: frame trigger, controls, follow target and camera result.
interface camera_controller_if #(
   parameter int WORLD_BITS = 18
);
   logic                         new_frame_in;
   logic [3:0]                   btn_in;
   logic                         fast_in;
   logic                         follow_in;
   logic                         snap_in;
   logic signed [WORLD_BITS-1:0] target_x_in;
   logic signed [WORLD_BITS-1:0] target_y_in;
   logic signed [WORLD_BITS-1:0] camera_x_out;
   logic signed [WORLD_BITS-1:0] camera_y_out;
   logic                         update_out;
   logic                         busy_out;
   logic                         overrun_out;

   modport master (
      output new_frame_in, btn_in, fast_in, follow_in, snap_in, target_x_in, target_y_in,
      input  camera_x_out, camera_y_out, update_out, busy_out, overrun_out
   );

   modport slave (
      input  new_frame_in, btn_in, fast_in, follow_in, snap_in, target_x_in, target_y_in,
      output camera_x_out, camera_y_out, update_out, busy_out, overrun_out
   );
endinterface

// File: rtl/camera_controller.sv
// Per-frame camera position update: manual stepping or smoothed target follow,
// clamped to the world bounds and committed through a fixed 4-state pipeline.
module camera_controller #(
   parameter int WORLD_BITS   = 18,
   parameter int INIT_X       = 640,
   parameter int INIT_Y       = 360,
   parameter int STEP_SMALL   = 5,
   parameter int STEP_LARGE   = 20,
   parameter int MIN_X        = 0,
   parameter int MAX_X        = 8191,
   parameter int MIN_Y        = 0,
   parameter int MAX_Y        = 2047,
   parameter int FOLLOW_SHIFT = 3
) (
   input logic                clk_in,
   input logic                rst_in,
   camera_controller_if.slave bus
);
   localparam int unsigned W  = WORLD_BITS;
   localparam int unsigned DW = WORLD_BITS + 1;
   localparam int unsigned EW = WORLD_BITS + 2;

   localparam logic signed [EW-1:0] MIN_X_E = EW'(MIN_X);
   localparam logic signed [EW-1:0] MAX_X_E = EW'(MAX_X);
   localparam logic signed [EW-1:0] MIN_Y_E = EW'(MIN_Y);
   localparam logic signed [EW-1:0] MAX_Y_E = EW'(MAX_Y);

   typedef enum logic [1:0] {IDLE, STEP, CLAMP, COMMIT} state_t;

   state_t state_q, state_d;

   logic [3:0]             btn_q;
   logic                   fast_q, follow_q, snap_q;
   logic signed [W-1:0]    tgt_x_q, tgt_y_q;
   logic signed [EW-1:0]   nxt_x_q, nxt_y_q;
   logic signed [W-1:0]    clp_x_q, clp_y_q;
   logic signed [W-1:0]    cam_x_q, cam_y_q;
   logic                   update_q, busy_q, overrun_q;
   logic signed [EW-1:0]   step_c;

   // Unclamped next coordinate for one axis, in a width that cannot overflow.
   function automatic logic signed [EW-1:0] axis_next(
      input logic signed [W-1:0]  cam,
      input logic signed [W-1:0]  tgt,
      input logic                 inc,
      input logic                 dec,
      input logic signed [EW-1:0] step,
      input logic                 follow,
      input logic                 snap
   );
      logic signed [DW-1:0] diff;
      logic signed [DW-1:0] delta;
      logic signed [EW-1:0] res;
      diff  = DW'(tgt) - DW'(cam);
      delta = diff >>> FOLLOW_SHIFT;
      // Small residual differences still move one unit so follow always converges.
      if (delta == '0 && diff != '0) delta = diff[DW-1] ? '1 : DW'(1);
      res = EW'(cam);
      if (follow) begin
         if (snap) res = EW'(tgt);
         else      res = EW'(cam) + EW'(delta);
      end else begin
         if (inc) res = res + step;
         if (dec) res = res - step;
      end
      return res;
   endfunction

   function automatic logic signed [W-1:0] clamp(
      input logic signed [EW-1:0] v,
      input logic signed [EW-1:0] lo,
      input logic signed [EW-1:0] hi
   );
      logic signed [EW-1:0] r;
      r = v;
      if (v < lo) r = lo;
      if (v > hi) r = hi;
      return W'(r);
   endfunction

   // State register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic: fixed walk through the pipeline once triggered.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (bus.new_frame_in) state_d = STEP;
         STEP:   state_d = CLAMP;
         CLAMP:  state_d = COMMIT;
         COMMIT: state_d = IDLE;
      endcase
   end

   assign step_c = fast_q ? EW'(STEP_LARGE) : EW'(STEP_SMALL);

   // Datapath and registered status outputs.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         btn_q     <= '0;
         fast_q    <= 1'b0;
         follow_q  <= 1'b0;
         snap_q    <= 1'b0;
         tgt_x_q   <= '0;
         tgt_y_q   <= '0;
         nxt_x_q   <= '0;
         nxt_y_q   <= '0;
         clp_x_q   <= '0;
         clp_y_q   <= '0;
         cam_x_q   <= W'(INIT_X);
         cam_y_q   <= W'(INIT_Y);
         update_q  <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         busy_q   <= (state_d != IDLE);
         update_q <= (state_q == COMMIT);
         if (bus.new_frame_in && state_q != IDLE) overrun_q <= 1'b1;
         unique case (state_q)
            IDLE: if (bus.new_frame_in) begin
               btn_q    <= bus.btn_in;
               fast_q   <= bus.fast_in;
               follow_q <= bus.follow_in;
               snap_q   <= bus.snap_in;
               tgt_x_q  <= bus.target_x_in;
               tgt_y_q  <= bus.target_y_in;
            end
            STEP: begin
               nxt_x_q <= axis_next(cam_x_q, tgt_x_q, btn_q[2], btn_q[3], step_c, follow_q, snap_q);
               nxt_y_q <= axis_next(cam_y_q, tgt_y_q, btn_q[0], btn_q[1], step_c, follow_q, snap_q);
            end
            CLAMP: begin
               clp_x_q <= clamp(nxt_x_q, MIN_X_E, MAX_X_E);
               clp_y_q <= clamp(nxt_y_q, MIN_Y_E, MAX_Y_E);
            end
            COMMIT: begin
               cam_x_q <= clp_x_q;
               cam_y_q <= clp_y_q;
            end
         endcase
      end
   end

   assign bus.camera_x_out = cam_x_q;
   assign bus.camera_y_out = cam_y_q;
   assign bus.update_out   = update_q;
   assign bus.busy_out     = busy_q;
   assign bus.overrun_out  = overrun_q;
endmodule

// File: tb/tb_camera_controller.sv
// Directed bench for camera_controller: manual, clamp, follow, overrun and mid-update reset.
module tb_camera_controller;
   localparam int W = 18;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   camera_controller_if #(.WORLD_BITS(W)) bus ();
   camera_controller dut (.clk_in(clk), .rst_in(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n = 1'b0;
      bus.new_frame_in = 1'b0; bus.btn_in = '0; bus.fast_in = 1'b0;
      bus.follow_in = 1'b0; bus.snap_in = 1'b0;
      bus.target_x_in = '0; bus.target_y_in = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Pulses one frame, scrambles the inputs afterwards, and reports edges until update_out.
   task automatic run_frame(input logic [3:0] b, input logic f, input logic fo, input logic s,
                            input int tx, input int ty, output int lat);
      bus.btn_in = b; bus.fast_in = f; bus.follow_in = fo; bus.snap_in = s;
      bus.target_x_in = W'(tx); bus.target_y_in = W'(ty);
      bus.new_frame_in = 1'b1;
      @(negedge clk);
      bus.new_frame_in = 1'b0;
      bus.btn_in = ~b; bus.fast_in = ~f; bus.follow_in = ~fo; bus.snap_in = ~s;
      bus.target_x_in = W'(-tx); bus.target_y_in = W'(-ty);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.update_out === 1'b1) begin lat = k; break; end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.camera_x_out !== 640) begin errors++; $display("FAIL reset_x got=%0d exp=640", bus.camera_x_out); end
      checks++; if (bus.camera_y_out !== 360) begin errors++; $display("FAIL reset_y got=%0d exp=360", bus.camera_y_out); end
      checks++; if (bus.update_out !== 1'b0) begin errors++; $display("FAIL reset_update got=%b exp=0", bus.update_out); end
      checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy_out); end
      checks++; if (bus.overrun_out !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun_out); end
   endtask

   task automatic test_manual();
      int lat;
      do_reset();
      run_frame(4'b0100, 1'b0, 1'b0, 1'b0, 0, 0, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL manual_latency got=%0d exp=3", lat); end
      checks++; if (bus.camera_x_out !== 645 || bus.camera_y_out !== 360) begin errors++; $display("FAIL manual_right got=(%0d,%0d) exp=(645,360)", bus.camera_x_out, bus.camera_y_out); end
      @(negedge clk);
      checks++; if (bus.update_out !== 1'b0) begin errors++; $display("FAIL manual_pulse_width got=%b exp=0", bus.update_out); end
      do_reset();
      run_frame(4'b0101, 1'b1, 1'b0, 1'b0, 0, 0, lat);
      checks++; if (bus.camera_x_out !== 660 || bus.camera_y_out !== 380) begin errors++; $display("FAIL manual_diag_fast got=(%0d,%0d) exp=(660,380)", bus.camera_x_out, bus.camera_y_out); end
      run_frame(4'b1100, 1'b1, 1'b0, 1'b0, 0, 0, lat);
      checks++; if (bus.camera_x_out !== 660 || bus.camera_y_out !== 380) begin errors++; $display("FAIL manual_cancel got=(%0d,%0d) exp=(660,380)", bus.camera_x_out, bus.camera_y_out); end
      run_frame(4'b0000, 1'b0, 1'b0, 1'b0, 0, 0, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL manual_idle_update got=%0d exp=3", lat); end
      checks++; if (bus.camera_x_out !== 660 || bus.camera_y_out !== 380) begin errors++; $display("FAIL manual_hold got=(%0d,%0d) exp=(660,380)", bus.camera_x_out, bus.camera_y_out); end
   endtask

   task automatic test_clamp();
      int lat;
      do_reset();
      run_frame(4'b0000, 1'b0, 1'b1, 1'b1, 8185, 2040, lat);
      checks++; if (bus.camera_x_out !== 8185 || bus.camera_y_out !== 2040) begin errors++; $display("FAIL clamp_setup_hi got=(%0d,%0d) exp=(8185,2040)", bus.camera_x_out, bus.camera_y_out); end
      run_frame(4'b0101, 1'b1, 1'b0, 1'b0, 0, 0, lat);
      checks++; if (bus.camera_x_out !== 8191 || bus.camera_y_out !== 2047) begin errors++; $display("FAIL clamp_max got=(%0d,%0d) exp=(8191,2047)", bus.camera_x_out, bus.camera_y_out); end
      run_frame(4'b0000, 1'b0, 1'b1, 1'b1, 3, 0, lat);
      run_frame(4'b1010, 1'b0, 1'b0, 1'b0, 0, 0, lat);
      checks++; if (bus.camera_x_out !== 0 || bus.camera_y_out !== 0) begin errors++; $display("FAIL clamp_min got=(%0d,%0d) exp=(0,0)", bus.camera_x_out, bus.camera_y_out); end
   endtask

   task automatic test_follow();
      int lat;
      do_reset();
      run_frame(4'b0000, 1'b0, 1'b1, 1'b0, 720, 360, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL follow_latency got=%0d exp=3", lat); end
      checks++; if (bus.camera_x_out !== 650 || bus.camera_y_out !== 360) begin errors++; $display("FAIL follow_step got=(%0d,%0d) exp=(650,360)", bus.camera_x_out, bus.camera_y_out); end
      run_frame(4'b0000, 1'b0, 1'b1, 1'b1, 716, 360, lat);
      run_frame(4'b0000, 1'b0, 1'b1, 1'b0, 720, 360, lat);
      checks++; if (bus.camera_x_out !== 717) begin errors++; $display("FAIL follow_min_step got=%0d exp=717", bus.camera_x_out); end
      run_frame(4'b0000, 1'b0, 1'b1, 1'b0, 700, 360, lat);
      checks++; if (bus.camera_x_out !== 714) begin errors++; $display("FAIL follow_negative got=%0d exp=714", bus.camera_x_out); end
      run_frame(4'b0000, 1'b0, 1'b1, 1'b1, 9000, -5, lat);
      checks++; if (bus.camera_x_out !== 8191 || bus.camera_y_out !== 0) begin errors++; $display("FAIL follow_snap_clamp got=(%0d,%0d) exp=(8191,0)", bus.camera_x_out, bus.camera_y_out); end
   endtask

   task automatic test_back_to_back();
      int ups;
      int lat;
      do_reset();
      bus.btn_in = 4'b0100; bus.fast_in = 1'b0; bus.follow_in = 1'b0; bus.snap_in = 1'b0;
      bus.new_frame_in = 1'b1;
      @(negedge clk);
      checks++; if (bus.busy_out !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", bus.busy_out); end
      @(negedge clk);
      bus.new_frame_in = 1'b0;
      ups = 0;
      for (int k = 0; k < 10; k++) begin
         if (bus.update_out === 1'b1) ups++;
         @(negedge clk);
      end
      checks++; if (ups !== 1) begin errors++; $display("FAIL b2b_update_count got=%0d exp=1", ups); end
      checks++; if (bus.camera_x_out !== 645) begin errors++; $display("FAIL b2b_x got=%0d exp=645", bus.camera_x_out); end
      checks++; if (bus.overrun_out !== 1'b1) begin errors++; $display("FAIL b2b_overrun got=%b exp=1", bus.overrun_out); end
      for (int k = 0; k < 10; k++) run_frame(4'b0000, 1'b0, 1'b0, 1'b0, 0, 0, lat);
      checks++; if (bus.overrun_out !== 1'b1) begin errors++; $display("FAIL b2b_overrun_sticky got=%b exp=1", bus.overrun_out); end
      do_reset();
      checks++; if (bus.overrun_out !== 1'b0) begin errors++; $display("FAIL b2b_overrun_clear got=%b exp=0", bus.overrun_out); end
      // Pulse landing on the commit cycle is an overrun, not a second update.
      bus.btn_in = 4'b0100; bus.new_frame_in = 1'b1;
      @(negedge clk); bus.new_frame_in = 1'b0;
      @(negedge clk);
      @(negedge clk); bus.new_frame_in = 1'b1;
      @(negedge clk); bus.new_frame_in = 1'b0;
      ups = 0;
      for (int k = 0; k < 8; k++) begin
         if (bus.update_out === 1'b1) ups++;
         @(negedge clk);
      end
      checks++; if (ups !== 1) begin errors++; $display("FAIL commit_pulse_updates got=%0d exp=1", ups); end
      checks++; if (bus.overrun_out !== 1'b1 || bus.camera_x_out !== 645) begin errors++; $display("FAIL commit_pulse_state got=(ovr=%b,x=%0d) exp=(ovr=1,x=645)", bus.overrun_out, bus.camera_x_out); end
   endtask

   task automatic test_reset_mid_update();
      int ups;
      int lat;
      do_reset();
      bus.btn_in = 4'b0101; bus.fast_in = 1'b1; bus.new_frame_in = 1'b1;
      @(negedge clk); bus.new_frame_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (bus.camera_x_out !== 640 || bus.camera_y_out !== 360) begin errors++; $display("FAIL midrst_pos got=(%0d,%0d) exp=(640,360)", bus.camera_x_out, bus.camera_y_out); end
      checks++; if (bus.busy_out !== 1'b0 || bus.update_out !== 1'b0) begin errors++; $display("FAIL midrst_flags got=(busy=%b,upd=%b) exp=(0,0)", bus.busy_out, bus.update_out); end
      @(negedge clk); rst_n = 1'b1;
      ups = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.update_out === 1'b1 || bus.busy_out === 1'b1) ups++;
      end
      checks++; if (ups !== 0 || bus.camera_x_out !== 640) begin errors++; $display("FAIL midrst_no_commit got=(act=%0d,x=%0d) exp=(0,640)", ups, bus.camera_x_out); end
      run_frame(4'b0101, 1'b1, 1'b0, 1'b0, 0, 0, lat);
      checks++; if (bus.camera_x_out !== 660 || bus.camera_y_out !== 380) begin errors++; $display("FAIL midrst_fresh got=(%0d,%0d) exp=(660,380)", bus.camera_x_out, bus.camera_y_out); end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.new_frame_in = 1'b0; bus.btn_in = '0; bus.fast_in = 1'b0;
      bus.follow_in = 1'b0; bus.snap_in = 1'b0;
      bus.target_x_in = '0; bus.target_y_in = '0;
      test_reset();
      test_manual();
      test_clamp();
      test_follow();
      test_back_to_back();
      test_reset_mid_update();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
